// File: rtl/taktowanie_pkg.sv
// Shared FSM state type and the tick-constant helpers used by the multi-channel
// ticks-per-degree calculator.
package taktowanie_pkg;

  typedef enum logic [1:0] {
    SKAN,
    LADUJ,
    DZIEL,
    ZAPISZ
  } stan_t;

  // Ticks per degree at 1 rpm: one degree takes 1/(6*rpm) s, so K = CLK_HZ/6.
  function automatic int k_of(input int clk_hz);
    return clk_hz / 6;
  endfunction

  function automatic int kw_of(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/dzielnik_sekwencyjny.sv
// Restoring divider, one quotient bit per cycle over KW cycles; start is accepted
// only when idle and done pulses during the final step.
module dzielnik_sekwencyjny #(
  parameter int DW = 10,
  parameter int KW = 10,
  parameter int RW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dzielna,
  input  logic [RW-1:0] dzielnik,
  output logic          done,
  output logic [KW-1:0] iloraz
);

  localparam int CW = $clog2(KW + 1);

  logic [RW-1:0] reszta;
  logic [RW-1:0] dzielnik_r;
  logic [KW-1:0] rejestr;
  logic [CW-1:0] licznik;
  logic          aktywny;
  logic [RW:0]   proba;
  logic          bit_q;

  always_comb begin
    proba = {reszta, rejestr[KW-1]};
    bit_q = (proba >= {1'b0, dzielnik_r});
  end

  // Bits above KW are preloaded as the partial remainder: the quotient always
  // fits in KW bits, so that prefix is already smaller than the divisor.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reszta     <= '0;
      dzielnik_r <= '0;
      rejestr    <= '0;
      licznik    <= '0;
      aktywny    <= 1'b0;
    end else if (start && !aktywny) begin
      reszta     <= RW'(dzielna >> KW);
      rejestr    <= dzielna[KW-1:0];
      dzielnik_r <= dzielnik;
      licznik    <= CW'(KW);
      aktywny    <= 1'b1;
    end else if (aktywny) begin
      reszta  <= bit_q ? RW'(proba - {1'b0, dzielnik_r}) : RW'(proba);
      rejestr <= {rejestr[KW-2:0], bit_q};
      licznik <= licznik - 1'b1;
      if (licznik == CW'(1)) aktywny <= 1'b0;
    end
  end

  assign done   = aktywny && (licznik == CW'(1));
  assign iloraz = rejestr;

endmodule

// File: rtl/obliczanie_taktowania_wielokanalowe.sv
// Per-channel ticks-per-degree (K/rpm) using one shared sequential divider.
// Macro TAKTOWANIE_ZAOKRAGLANIE_EN selects round-to-nearest instead of truncation.
module obliczanie_taktowania_wielokanalowe
  import taktowanie_pkg::*;
#(
  parameter int CLK_HZ = 6000,
  parameter int NUM_CH = 2,
  parameter int RPM_W  = 7,
  parameter int OUT_W  = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*RPM_W-1:0] rpm,
  output logic [NUM_CH*OUT_W-1:0] taktowanie_na_stopien,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH-1:0]       przepelnienie,
  output logic                    busy
);

  localparam int K  = k_of(CLK_HZ);
  localparam int KW = kw_of(K);
`ifdef TAKTOWANIE_ZAOKRAGLANIE_EN
  localparam int DW = $clog2(K + (2**RPM_W - 1) / 2 + 1);
`else
  localparam int DW = KW;
`endif
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [OUT_W-1:0] PELNE = '1;

  stan_t           stan, stan_nast;
  logic [PW-1:0]   wsk;
  logic [RPM_W-1:0] rpm_ch  [NUM_CH];
  logic [RPM_W-1:0] rpm_zap [NUM_CH];
  logic [OUT_W-1:0] wynik   [NUM_CH];
  logic [NUM_CH-1:0] zainicjowany;
  logic [RPM_W-1:0] rpm_biez, rpm_lat;
  logic            niezgodnosc, start, done, nadmiar;
  logic [DW-1:0]   dzielna;
  logic [KW-1:0]   iloraz;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_kanal
    assign rpm_ch[c] = rpm[c*RPM_W +: RPM_W];
    assign taktowanie_na_stopien[c*OUT_W +: OUT_W] = wynik[c];
  end

  assign rpm_biez    = rpm_ch[wsk];
  assign niezgodnosc = !zainicjowany[wsk] || (rpm_biez != rpm_zap[wsk]);
  assign nadmiar     = 32'(iloraz) > 32'(PELNE);

`ifdef TAKTOWANIE_ZAOKRAGLANIE_EN
  assign dzielna = DW'(K) + DW'(rpm_biez >> 1);
`else
  assign dzielna = DW'(K);
`endif

  function automatic logic [PW-1:0] nastepny(input logic [PW-1:0] w);
    return (w == PW'(NUM_CH - 1)) ? '0 : w + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stan <= SKAN;
    else        stan <= stan_nast;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    stan_nast = stan;
    unique case (stan)
      SKAN:   if (niezgodnosc) stan_nast = LADUJ;
      LADUJ:  stan_nast = (rpm_biez == '0) ? ZAPISZ : DZIEL;
      DZIEL:  if (done) stan_nast = ZAPISZ;
      ZAPISZ: stan_nast = SKAN;
      default: stan_nast = SKAN;
    endcase
  end

  always_comb begin
    busy  = (stan != SKAN);
    start = (stan == LADUJ) && (rpm_biez != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsk <= '0;
    end else if ((stan == SKAN && !niezgodnosc) || stan == ZAPISZ) begin
      wsk <= nastepny(wsk);
    end
  end

  // NOTE: per-channel storage is reset as well; the cleared init flags force a
  // fresh compute, and known stored values keep outputs deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rpm_zap[c] <= '0;
        wynik[c]   <= '0;
      end
      zainicjowany  <= '0;
      valid         <= '0;
      przepelnienie <= '0;
      rpm_lat       <= '0;
    end else begin
      unique case (stan)
        SKAN: if (niezgodnosc) valid[wsk] <= 1'b0;
        LADUJ: begin
          rpm_zap[wsk]      <= rpm_biez;
          zainicjowany[wsk] <= 1'b1;
          rpm_lat           <= rpm_biez;
        end
        ZAPISZ: begin
          valid[wsk] <= 1'b1;
          if (rpm_lat == '0) begin
            wynik[wsk]         <= PELNE;
            przepelnienie[wsk] <= 1'b0;
          end else begin
            wynik[wsk]         <= nadmiar ? PELNE : OUT_W'(iloraz);
            przepelnienie[wsk] <= nadmiar;
          end
        end
        default: ;
      endcase
    end
  end

  dzielnik_sekwencyjny #(
    .DW(DW),
    .KW(KW),
    .RW(RPM_W)
  ) u_dzielnik (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dzielna (dzielna),
    .dzielnik(rpm_biez),
    .done    (done),
    .iloraz  (iloraz)
  );

endmodule

// File: tb/tb_obliczanie_taktowania_wielokanalowe.sv
// Directed bench for the multi-channel ticks-per-degree calculator (K=1000, KW=10),
// expectations hand-computed for both rounding builds.
module tb_obliczanie_taktowania_wielokanalowe;

  localparam int NUM_CH = 2;
  localparam int RPM_W  = 7;
  localparam int OUT_W  = 9;
`ifdef TAKTOWANIE_ZAOKRAGLANIE_EN
  localparam int EXP_R7   = 143;
  localparam int EXP_R127 = 8;
`else
  localparam int EXP_R7   = 142;
  localparam int EXP_R127 = 7;
`endif

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*RPM_W-1:0] rpm;
  logic [NUM_CH*OUT_W-1:0] taktowanie_na_stopien;
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH-1:0]       przepelnienie;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  obliczanie_taktowania_wielokanalowe #(
    .CLK_HZ(6000),
    .NUM_CH(NUM_CH),
    .RPM_W (RPM_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rpm                  (rpm),
    .taktowanie_na_stopien(taktowanie_na_stopien),
    .valid                (valid),
    .przepelnienie        (przepelnienie),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sprawdz(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] wyn(input int ch);
    return taktowanie_na_stopien[ch*OUT_W +: OUT_W];
  endfunction

  task automatic ustaw(input int ch, input int v);
    rpm[ch*RPM_W +: RPM_W] = RPM_W'(v);
  endtask

  // Waits (bounded) until channel ch shows a valid result equal to exp.
  task automatic czekaj(input int ch, input int exp, input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (valid[ch] && wyn(ch) == OUT_W'(exp)) ok = 1'b1;
    end
    sprawdz({tag, " in time"}, 32'(ok), 32'd1);
    sprawdz({tag, " value"}, 32'(wyn(ch)), 32'(exp));
  endtask

  task automatic czekaj_busy(input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
    sprawdz(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    rpm   = '0;
    repeat (3) @(negedge clk);
    sprawdz("reset results", 32'(taktowanie_na_stopien), 32'd0);
    sprawdz("reset valid", 32'(valid), 32'd0);
    sprawdz("reset busy", 32'(busy), 32'd0);

    // rpm=0 on both channels: divider bypass, all-ones without overflow flag
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (valid == 2'b11) ok = 1'b1;
    end
    sprawdz("init valid in time", 32'(ok), 32'd1);
    sprawdz("init ch0", 32'(wyn(0)), 32'd511);
    sprawdz("init ch1", 32'(wyn(1)), 32'd511);
    sprawdz("init przep", 32'(przepelnienie), 32'd0);

    ustaw(0, 5);
    czekaj(0, 200, 14, "ch0 rpm5");
    sprawdz("ch0 rpm5 przep", 32'(przepelnienie[0]), 32'd0);
    sprawdz("ch1 untouched", 32'(wyn(1)), 32'd511);
    sprawdz("ch1 valid kept", 32'(valid[1]), 32'd1);

    ustaw(1, 7);
    czekaj(1, EXP_R7, 14, "ch1 rpm7");
    sprawdz("ch0 kept 200", 32'(wyn(0)), 32'd200);

    ustaw(0, 1);
    czekaj(0, 511, 14, "ch0 rpm1");
    sprawdz("ch0 rpm1 przep", 32'(przepelnienie[0]), 32'd1);
    ustaw(0, 127);
    czekaj(0, EXP_R127, 14, "ch0 rpm127");
    sprawdz("ch0 rpm127 przep", 32'(przepelnienie[0]), 32'd0);

    // rpm change on the 4th DZIEL cycle: stale 200 first, then 333
    ustaw(0, 5);
    czekaj_busy(6, "busy for rpm5");
    repeat (4) @(negedge clk);
    sprawdz("busy in DZIEL", 32'(busy), 32'd1);
    ustaw(0, 3);
    czekaj(0, 200, 14, "stale 200");
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (!valid[0]) ok = 1'b1;
    end
    sprawdz("valid0 drops on mismatch", 32'(ok), 32'd1);
    czekaj(0, 333, 16, "ch0 rpm3");

    // reset pulse mid-division
    ustaw(1, 10);
    czekaj_busy(6, "busy for ch1 rpm10");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sprawdz("midreset results", 32'(taktowanie_na_stopien), 32'd0);
    sprawdz("midreset valid", 32'(valid), 32'd0);
    sprawdz("midreset przep", 32'(przepelnienie), 32'd0);
    sprawdz("midreset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (valid == 2'b11) ok = 1'b1;
    end
    sprawdz("recompute in time", 32'(ok), 32'd1);
    sprawdz("recompute ch0", 32'(wyn(0)), 32'd333);
    sprawdz("recompute ch1", 32'(wyn(1)), 32'd100);
    sprawdz("recompute przep", 32'(przepelnienie), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obliczanie_taktowania_wielokanalowe.md
OBLICZANIE_TAKTOWANIA_WIELOKANALOWE -- requirements
Module: obliczanie_taktowania_wielokanalowe

Interface
REQ-001 SHALL have parameter CLK_HZ, default 6000: system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CH, default 2: number of motor channels.
REQ-003 SHALL have parameter RPM_W, default 7: width of one rpm value.
REQ-004 SHALL have parameter OUT_W, default 9: width of one ticks-per-degree result.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port rpm, input, NUM_CH*RPM_W bits: per-channel rpm; channel c is at bits [c*RPM_W +: RPM_W].
REQ-008 SHALL have port taktowanie_na_stopien, output, NUM_CH*OUT_W bits: per-channel clock ticks per degree, packed the same way.
REQ-009 SHALL have port valid, output, NUM_CH bits: channel result is current.
REQ-010 SHALL have port przepelnienie, output, NUM_CH bits: channel result saturated.
REQ-011 SHALL have port busy, output, 1 bit: divider in use.

Function
REQ-012 SHALL compute per channel: result = K / rpm, where K = CLK_HZ/6 (constant, truncated) and KW = $clog2(K+1).
REQ-013 SHALL use one shared sequential divider producing one quotient bit per cycle, KW cycles per division.
REQ-014 SHALL run FSM states SKAN, LADUJ, DZIEL, ZAPISZ.
- SKAN: check one channel per cycle, round-robin 0..NUM_CH-1 wrapping to 0.
- SKAN->LADUJ when the checked channel is uninitialised or its rpm differs from its stored rpm.
- LADUJ: 1 cycle; sample rpm, store it as the channel's last rpm.
- DZIEL: KW cycles.
- ZAPISZ: 1 cycle; write result; return to SKAN at the next channel.
REQ-015 SHALL drop valid[c] in the cycle a mismatch on channel c is detected, and set it again in ZAPISZ.
REQ-016 SHALL hold busy high in LADUJ, DZIEL and ZAPISZ.
REQ-017 SHALL, for rpm==0, bypass the divider (LADUJ->ZAPISZ) and write all-ones with przepelnienie=0.
REQ-018 SHALL, when the quotient exceeds 2^OUT_W-1, write all-ones with przepelnienie=1; otherwise write the quotient with przepelnienie=0.
REQ-019 SHALL, when rpm changes during DZIEL, finish and store the stale result; the next scan of that channel detects the mismatch and recomputes.
REQ-020 SHALL update a result within NUM_CH+KW+2 cycles of its rpm becoming stable.
REQ-021 SHALL keep the other channels' results and valid bits unchanged while one channel is recomputed.

Reset
REQ-022 SHALL, while rst_n=0, clear immediately: all results to 0, valid, przepelnienie and busy to 0, and all channels to uninitialised.
REQ-023 SHALL set the FSM to SKAN and the scan pointer to channel 0 on reset.
REQ-024 SHALL abandon a division in progress when reset is asserted; no partial result is written.

Configuration
REQ-025 SHALL support macro TAKTOWANIE_ZAOKRAGLANIE_EN.
- Defined: dividend = K + floor(rpm/2), giving round-to-nearest.
- Undefined: dividend = K, giving truncation.
- Dividend width SHALL be sized so the addition cannot wrap.

Structure
REQ-026 SHALL take the FSM state enum and the K/KW constant functions from the shared package taktowanie_pkg.
REQ-027 SHALL implement the divider as sub-module dzielnik_sekwencyjny with a start/done handshake: start accepted only when idle, done a 1-cycle pulse.

Verification (defaults: K=1000, KW=10)
REQ-028 SHALL check: reset release with rpm={0,0} -> both channels 511, valid=2'b11, przepelnienie=0, within 8 cycles.
REQ-029 SHALL check: ch0 rpm=5 -> ch0 result 200, przepelnienie[0]=0, within 14 cycles; ch1 unchanged.
REQ-030 SHALL check: ch1 rpm=7 -> 142 without the macro, 143 with TAKTOWANIE_ZAOKRAGLANIE_EN.
REQ-031 SHALL check: ch0 rpm=1 -> result 511, przepelnienie[0]=1; then rpm=127 -> result 7, przepelnienie[0]=0.
REQ-032 SHALL check: ch0 rpm 5->3 at the 4th DZIEL cycle -> 200 stored first, then 333; valid[0] low between.
REQ-033 SHALL check: rst_n pulsed low mid-DZIEL -> outputs 0 immediately, busy=0; full recompute after release.
